// File: rtl/img_pkg.sv
// Shared types for the SRAM image loader/streamer pair.
// Latency: none (types and defaults only).
// Backpressure: not applicable.
package img_pkg;

   localparam int DEF_PIX_W = 8;
   localparam int DEF_DIM_W = 8;

   typedef logic [DEF_PIX_W-1:0] pix_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } stream_state_t;

   typedef struct packed {
      logic valid;
      logic eol;
      logic eof;
   } pix_tag_t;

endpackage

// File: rtl/img_sram_intf.sv
// Row/column addressed image SRAM port; the master drives the address and controls.
// Latency: set by the SRAM behind the slave modport.
// Backpressure: none.
interface img_sram_intf #(
   parameter int PIX_W = 8,
   parameter int DIM_W = 8
);
   logic [DIM_W-1:0] row;
   logic [DIM_W-1:0] col;
   logic             sense_en;
   logic             write_en;
   logic [PIX_W-1:0] din;
   logic [PIX_W-1:0] dout;

   modport mst (output row, col, sense_en, write_en, din, input dout);
   modport slv (input row, col, sense_en, write_en, din, output dout);
endinterface

// File: rtl/img_sram_streamer_lat_pipe.sv
// Reset-clearable shift register that delays a tag to line up with SRAM read data.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; it shifts every cycle.
module lat_pipe #(
   parameter type T     = logic,
   parameter int  DEPTH = 1
) (
   input  logic clk,
   input  logic rstn,
   input  T     din,
   output T     dout
);

   T stage [DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/img_sram_streamer.sv
// Streams an nrows x ncols image out of img_sram in raster order, one pixel per clock.
// Latency: first pixel RD_LAT+2 cycles after the en cycle; done one cycle after the last pixel.
// Backpressure: none; the consumer must accept every valid pixel.
module img_sram_streamer
   import img_pkg::*;
#(
   parameter int PIX_W  = DEF_PIX_W,
   parameter int DIM_W  = DEF_DIM_W,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [DIM_W-1:0] nrows,
   input  logic [DIM_W-1:0] ncols,
   output logic [PIX_W-1:0] dout,
   output logic             dout_valid,
   output logic             dout_eol,
   output logic             dout_eof,
   output logic             busy,
   output logic             done,
   img_sram_intf.mst        sram_img
);

   stream_state_t    state, nxt_state;
   logic [DIM_W-1:0] r, c, nr, nc;
   logic             last_col, last_row;
   pix_tag_t         issue_tag, head_tag;

   // Compare against dims-1 so a 255-wide image never needs a 256 count.
   assign last_col = (c == nc - DIM_W'(1));
   assign last_row = (r == nr - DIM_W'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      issue_tag = '0;
      case (state)
         IDLE: begin
            if (en) nxt_state = (nrows == '0 || ncols == '0) ? DONE : STREAM;
         end
         STREAM: begin
            issue_tag = '{valid: 1'b1, eol: last_col, eof: last_col && last_row};
            if (last_col && last_row) nxt_state = DRAIN;
         end
         DRAIN: begin
            if (dout_valid && dout_eof) nxt_state = DONE;
         end
         DONE: nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r  <= '0;
         c  <= '0;
         nr <= '0;
         nc <= '0;
      end else if (state == IDLE && en) begin
         r  <= '0;
         c  <= '0;
         nr <= nrows;
         nc <= ncols;
      end else if (state == STREAM) begin
         if (last_col) begin
            c <= '0;
            if (!last_row) r <= r + DIM_W'(1);
         end else begin
            c <= c + DIM_W'(1);
         end
      end
   end

   assign sram_img.sense_en = (state == STREAM);
   assign sram_img.row      = r;
   assign sram_img.col      = c;
   assign sram_img.write_en = 1'b0;
   assign sram_img.din      = '0;

   lat_pipe #(.T(pix_tag_t), .DEPTH(RD_LAT)) u_tag_pipe (
      .clk  (clk),
      .rstn (rstn),
      .din  (issue_tag),
      .dout (head_tag)
   );

   // dout holds the last pixel between frames; only the markers drop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_eol   <= 1'b0;
         dout_eof   <= 1'b0;
      end else if (head_tag.valid) begin
         dout       <= sram_img.dout;
         dout_valid <= 1'b1;
         dout_eol   <= head_tag.eol;
         dout_eof   <= head_tag.eof;
      end else begin
         dout_valid <= 1'b0;
         dout_eol   <= 1'b0;
         dout_eof   <= 1'b0;
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_img_sram_streamer.sv
// Directed bench for img_sram_streamer with a one-cycle-latency SRAM model.
module tb_img_sram_streamer;

   logic       clk;
   logic       rstn;
   logic       en;
   logic [7:0] nrows;
   logic [7:0] ncols;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_eol;
   logic       dout_eof;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [0:65535];

   img_sram_intf #(.PIX_W(8), .DIM_W(8)) sif ();

   img_sram_streamer #(.PIX_W(8), .DIM_W(8), .RD_LAT(1)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .nrows      (nrows),
      .ncols      (ncols),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_eol   (dout_eol),
      .dout_eof   (dout_eof),
      .busy       (busy),
      .done       (done),
      .sram_img   (sif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial sif.dout = '0;
   always @(posedge clk) begin
      if (sif.sense_en) sif.dout <= mem[{sif.row, sif.col}];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_hash(input int seed);
      for (int a = 0; a < 65536; a++) mem[a] = 8'((a * 37) + ((a >> 8) * 11) + seed);
   endtask

   // en is high in cycle 0; cycle k is observed at the negedge after the k-th rising edge.
   task automatic run_frame(input int nr, input int nc, input int alt_nr, input int alt_nc,
                            input int repulse);
      int total, dcyc, nvalid, ndone, idx, pr, pc;
      logic exp_v;
      total  = nr * nc;
      dcyc   = (total == 0) ? 1 : total + 3;
      nvalid = 0;
      ndone  = 0;
      @(negedge clk);
      nrows = 8'(nr);
      ncols = 8'(nc);
      en    = 1'b1;
      for (int cyc = 1; cyc <= dcyc + 2; cyc++) begin
         @(negedge clk);
         en    = (cyc == repulse);
         nrows = 8'(alt_nr);
         ncols = 8'(alt_nc);
         exp_v = (total > 0) && (cyc >= 3) && (cyc <= total + 2);
         check_eq("valid", 32'(dout_valid), 32'(exp_v));
         check_eq("busy", 32'(busy), 32'(cyc <= dcyc));
         check_eq("done", 32'(done), 32'(cyc == dcyc));
         if (dout_valid) nvalid++;
         if (done) ndone++;
         if (exp_v) begin
            idx = cyc - 3;
            pr  = idx / nc;
            pc  = idx % nc;
            check_eq("pix", 32'(dout), 32'(mem[{pr[7:0], pc[7:0]}]));
            check_eq("eol", 32'(dout_eol), 32'(pc == nc - 1));
            check_eq("eof", 32'(dout_eof), 32'(idx == total - 1));
         end
      end
      en = 1'b0;
      check_eq("npix", 32'(nvalid), 32'(total));
      check_eq("ndone", 32'(ndone), 32'd1);
   endtask

   initial begin
      int  nv;
      logic found;
      rstn  = 1'b0;
      en    = 1'b0;
      nrows = '0;
      ncols = '0;
      #1;
      check_eq("rst_valid", 32'(dout_valid), 32'd0);
      check_eq("rst_dout", 32'(dout), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_sense", 32'(sif.sense_en), 32'd0);
      check_eq("rst_wen", 32'(sif.write_en), 32'd0);
      check_eq("rst_addr", 32'({sif.row, sif.col}), 32'd0);
      check_eq("rst_din", 32'(sif.din), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // 4x4 ramp: pixels 0..15, first valid cycle 3, done cycle 19
      fill_hash(0);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) mem[r * 256 + c] = 8'(r * 4 + c);
      run_frame(4, 4, 4, 4, 0);

      fill_hash(3);
      run_frame(128, 128, 128, 128, 0);

      run_frame(0, 5, 0, 5, 0);

      // restart attempt with new dims mid-frame must be ignored
      fill_hash(9);
      run_frame(3, 5, 2, 2, 6);

      // reset while pixel 37 of an 8x8 frame is on the output
      fill_hash(5);
      @(negedge clk);
      nrows = 8'd8;
      ncols = 8'd8;
      en    = 1'b1;
      @(negedge clk);
      en    = 1'b0;
      nv    = 0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (dout_valid) begin
            if (nv == 37) found = 1'b1;
            nv++;
         end
         if (!found) @(negedge clk);
      end
      check_eq("abort_reach", 32'(found), 32'd1);
      check_eq("abort_pix", 32'(dout), 32'(mem[{8'd4, 8'd5}]));
      rstn = 1'b0;
      #1;
      check_eq("abort_valid", 32'(dout_valid), 32'd0);
      check_eq("abort_dout", 32'(dout), 32'd0);
      check_eq("abort_flags", 32'({dout_eol, dout_eof}), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_sense", 32'(sif.sense_en), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("abort_done", 32'(done), 32'd0);
      end
      rstn = 1'b1;
      run_frame(8, 8, 8, 8, 0);

      fill_hash(17);
      run_frame(1, 255, 1, 255, 0);
      run_frame(255, 1, 255, 1, 0);

      check_eq("wen_end", 32'(sif.write_en), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
